deletion_locator_seq: RTL and testbench

//  Sequential, handshaked successor to the combinational single-deletion locator in the DNA decode path.

---
 rtl/dna_code_pkg.sv | 26 ++
 rtl/dna_syn_mod.sv | 32 +++
 rtl/deletion_locator_seq.sv | 232 +++++++++++++++++++++++
 tb/tb_deletion_locator_seq.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/dna_code_pkg.sv
// Shared types and helpers for the DNA single-deletion decode path.
// Quaternary symbols are 2 bits; symbol value 0 stands for weight 4.
package dna_code_pkg;

   typedef logic [1:0] sym_t;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SCAN_A,
      SCAN_B,
      DONE
   } loc_state_e;

   typedef enum logic [1:0] {
      CASE_A,
      CASE_B,
      CASE_C
   } loc_case_e;

   // Weight of a symbol: 1..3 as-is, 0 counts as 4.
   function automatic logic [2:0] sym_val(input sym_t s);
      return (s == 2'd0) ? 3'd4 : {1'b0, s};
   endfunction

endpackage

// File: rtl/dna_syn_mod.sv
// Residue generator for the deletion locator.
// Turns the signed syndrome difference r into delta = r mod 4N in [0,4N)
// and gamma = r mod 4 in 1..4 (a zero residue is reported as 4).
module dna_syn_mod
   import dna_code_pkg::*;
#(
   parameter  int N     = 100,
   parameter  int R_W   = 16,
   localparam int DEL_W = $clog2(N) + 3
) (
   input  logic signed [R_W-1:0]   r,
   output logic        [DEL_W-1:0] delta,
   output logic        [2:0]       gamma
);

   localparam logic signed [R_W-1:0] MOD_S = R_W'(4 * N);

   logic signed [R_W-1:0] rem;

   // Signed remainder truncates toward zero, so fold negative results up.
   always_comb begin
      // NOTE: combinational blocks use blocking '=' so later statements see
      // the value just computed; non-blocking here would read stale values.
      rem = r % MOD_S;
      if (rem < 0) rem = rem + MOD_S;
   end

   assign delta = DEL_W'(rem);
   // Two's complement low bits already give the non-negative residue mod 4.
   assign gamma = sym_val(sym_t'(r[1:0]));

endmodule

// File: rtl/deletion_locator_seq.sv
// Sequential single-deletion locator with valid/ready handshakes.
// Scans one symbol per cycle and reports the deleted position and symbol.
// Optional feature: define DELLOC_NOMATCH_ERR_EN to add the out_err port,
// which flags pointer exhaustion in SCAN_A and a failed search in SCAN_B.
module deletion_locator_seq
   import dna_code_pkg::*;
#(
   parameter  int N     = 100,
   parameter  int A     = 30,
   parameter  int B     = 27,
   parameter  int SYN_W = 14,
   parameter  int SUM_W = 10,
   localparam int IDX_W = $clog2(N)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2*(N-1)-1:0] word_in,
   input  logic [2*(N-1)-1:0] diff_word,
   input  logic [SUM_W-1:0]   diff_sum,
   input  logic [SYN_W-1:0]   inv_syn,
   input  logic               reverse,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [IDX_W-1:0]   miss_index,
   output logic [1:0]         miss_digit
`ifdef DELLOC_NOMATCH_ERR_EN
   ,
   output logic               out_err
`endif
);

   localparam int R_W    = SYN_W + 2;
   localparam int DEL_W  = IDX_W + 3;
   localparam int SUM_X  = SUM_W + 2;
   localparam int CMP_W  = ((SUM_X > DEL_W) ? SUM_X : DEL_W) + 1;
   localparam int WORD_W = 2 * (N - 1);

   localparam logic signed [R_W-1:0] K_A     = R_W'(A);
   localparam logic signed [R_W-1:0] K_B     = R_W'(B);
   localparam logic        [IDX_W-1:0] LAST    = IDX_W'(N - 2);
   localparam logic        [IDX_W-1:0] TOP_IDX = IDX_W'(N - 1);

   loc_state_e state_q, state_d;
   loc_case_e  setup_case;

   logic [WORD_W-1:0] word_q, diff_q;
   logic [SUM_W-1:0]  diff_sum_q;
   logic [SYN_W-1:0]  inv_syn_q;
   logic              reverse_q;

   logic [DEL_W-1:0]  delta_q, delta_d;
   logic [2:0]        gamma_q, gamma_d;
   logic [SUM_X-1:0]  sum_q, sum_d;
   logic [IDX_W-1:0]  cnt_q, cnt_d;
   logic [IDX_W-1:0]  index_d;
   logic [1:0]        digit_d;
`ifdef DELLOC_NOMATCH_ERR_EN
   logic              err_d;
`endif

   logic signed [R_W-1:0] r_val;
   logic [DEL_W-1:0]  syn_delta;
   logic [2:0]        syn_gamma;

   logic [IDX_W-1:0]  sym_idx;
   sym_t              diff_sym, word_sym;
   logic [2:0]        diff_val, word_val, a_val;
   logic [SUM_X-1:0]  sum_a, sum_b;
   logic [CMP_W-1:0]  b_target;

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);

   // Residues are only consumed in SETUP, from the captured request.
   assign r_val = (reverse_q ? K_B : K_A) - $signed({2'b00, inv_syn_q});

   dna_syn_mod #(
      .N   (N),
      .R_W (R_W)
   ) u_syn (
      .r     (r_val),
      .delta (syn_delta),
      .gamma (syn_gamma)
   );

   // SCAN_A walks the difference word from the top; SCAN_B from the bottom.
   assign sym_idx  = (state_q == SCAN_A) ? (LAST - cnt_q) : cnt_q;
   assign diff_sym = diff_q[{sym_idx, 1'b0} +: 2];
   assign word_sym = word_q[{cnt_q, 1'b0} +: 2];
   assign diff_val = sym_val(diff_sym);
   assign word_val = sym_val(word_sym);
   // a = gamma - val(word[j]), lifted into 1..4 when not positive.
   assign a_val    = (gamma_q > word_val) ? (gamma_q - word_val)
                                          : (gamma_q + 3'd4 - word_val);
   assign sum_a    = sum_q + SUM_X'(diff_val);
   assign sum_b    = sum_q - SUM_X'(diff_val);
   assign b_target = CMP_W'(a_val) + CMP_W'(sum_q) + CMP_W'({cnt_q, 2'b00});

   // Classify the request by where delta falls relative to diff_sum.
   always_comb begin
      setup_case = CASE_C;
      if (CMP_W'(syn_delta) < CMP_W'(diff_sum_q))
         setup_case = CASE_A;
      else if (CMP_W'(syn_delta) >= CMP_W'(diff_sum_q) + CMP_W'(4))
         setup_case = CASE_B;
   end

   // Next-state and datapath updates for the locator FSM.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // it unassigned; a missed path would infer a latch.
      state_d = state_q;
      delta_d = delta_q;
      gamma_d = gamma_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      index_d = miss_index;
      digit_d = miss_digit;
`ifdef DELLOC_NOMATCH_ERR_EN
      err_d   = out_err;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) state_d = SETUP;
         end
         SETUP: begin
            delta_d = syn_delta;
            gamma_d = syn_gamma;
            digit_d = syn_gamma[1:0];
            cnt_d   = '0;
`ifdef DELLOC_NOMATCH_ERR_EN
            err_d   = 1'b0;
`endif
            case (setup_case)
               CASE_A: begin
                  sum_d   = '0;
                  state_d = SCAN_A;
               end
               CASE_B: begin
                  sum_d   = SUM_X'(diff_sum_q);
                  state_d = SCAN_B;
               end
               default: begin
                  index_d = TOP_IDX;
                  state_d = DONE;
               end
            endcase
         end
         SCAN_A: begin
            // The threshold is tested on the running sum including this
            // symbol, so the reported index is the count before the step.
            if (CMP_W'(sum_a) >= CMP_W'(delta_q)) begin
               index_d = cnt_q;
               state_d = DONE;
            end else if (cnt_q == LAST) begin
               index_d = LAST;
`ifdef DELLOC_NOMATCH_ERR_EN
               err_d   = 1'b1;
`endif
               state_d = DONE;
            end else begin
               sum_d = sum_a;
               cnt_d = cnt_q + IDX_W'(1);
            end
         end
         SCAN_B: begin
            if (CMP_W'(delta_q) == b_target) begin
               index_d = TOP_IDX - cnt_q;
               state_d = DONE;
            end else if (cnt_q == LAST) begin
               index_d = '0;
`ifdef DELLOC_NOMATCH_ERR_EN
               err_d   = 1'b1;
`endif
               state_d = DONE;
            end else begin
               sum_d = sum_b;
               cnt_d = cnt_q + IDX_W'(1);
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Control state, scan counters and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking '<=' so all registers update
      // together from pre-edge values, independent of statement order.
      if (!rst_n) begin
         state_q    <= IDLE;
         delta_q    <= '0;
         gamma_q    <= '0;
         sum_q      <= '0;
         cnt_q      <= '0;
         miss_index <= '0;
         miss_digit <= '0;
`ifdef DELLOC_NOMATCH_ERR_EN
         out_err    <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         delta_q    <= delta_d;
         gamma_q    <= gamma_d;
         sum_q      <= sum_d;
         cnt_q      <= cnt_d;
         miss_index <= index_d;
         miss_digit <= digit_d;
`ifdef DELLOC_NOMATCH_ERR_EN
         out_err    <= err_d;
`endif
      end
   end

   // Request capture on accept.
   always_ff @(posedge clk) begin
      // NOTE: the wide capture registers carry no reset; they are always
      // written at accept before the FSM reads them, so resetting buys nothing.
      if (in_valid && in_ready) begin
         word_q     <= word_in;
         diff_q     <= diff_word;
         diff_sum_q <= diff_sum;
         inv_syn_q  <= inv_syn;
         reverse_q  <= reverse;
      end
   end

endmodule

// File: tb/tb_deletion_locator_seq.sv
// Directed bench for deletion_locator_seq at N=8, A=30, B=27.
// Checks out_err as well when built with DELLOC_NOMATCH_ERR_EN.
module tb_deletion_locator_seq;

   localparam int N = 8;
   localparam int W = 2 * (N - 1);

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid, in_ready;
   logic [W-1:0]  word_in, diff_word;
   logic [9:0]    diff_sum;
   logic [13:0]   inv_syn;
   logic          reverse;
   logic          out_valid, out_ready;
   logic [2:0]    miss_index;
   logic [1:0]    miss_digit;
`ifdef DELLOC_NOMATCH_ERR_EN
   logic          out_err;
`endif

   int n_checks = 0;
   int n_errs   = 0;

   always #5 clk = ~clk;

   deletion_locator_seq #(
      .N     (N),
      .A     (30),
      .B     (27),
      .SYN_W (14),
      .SUM_W (10)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .word_in    (word_in),
      .diff_word  (diff_word),
      .diff_sum   (diff_sum),
      .inv_syn    (inv_syn),
      .reverse    (reverse),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .miss_index (miss_index),
      .miss_digit (miss_digit)
`ifdef DELLOC_NOMATCH_ERR_EN
      ,
      .out_err    (out_err)
`endif
   );

   typedef struct {
      logic [W-1:0] word;
      logic [W-1:0] diff;
      logic [9:0]   dsum;
      logic [13:0]  inv;
      logic         rev;
      logic [2:0]   idx;
      logic [1:0]   dig;
      logic         err;
      int           lat;   // 0: latency not checked
   } vec_t;

   vec_t vecs [15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      word_in   = v.word;
      diff_word = v.diff;
      diff_sum  = v.dsum;
      inv_syn   = v.inv;
      reverse   = v.rev;
   endtask

   // Issue one request and compare the result once out_valid rises.
   // Latency counts edges from the accept edge (1) to the first out_valid.
   task automatic run_vec(input int k, input vec_t v);
      int lat;
      check($sformatf("v%0d in_ready", k), in_ready, 1);
      drive(v);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check($sformatf("v%0d out_valid", k), out_valid, 1);
      check($sformatf("v%0d index", k), miss_index, v.idx);
      check($sformatf("v%0d digit", k), miss_digit, v.dig);
      if (v.lat != 0) check($sformatf("v%0d latency", k), lat, v.lat);
`ifdef DELLOC_NOMATCH_ERR_EN
      check($sformatf("v%0d err", k), out_err, v.err);
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      // word, diff, diff_sum, inv_syn, reverse, index, digit, err, latency
      vecs[0]  = '{14'h2AAA, 14'h1555, 10'd10, 14'd17,    1'b0, 3'd7, 2'd1, 1'b0, 2}; // 2c, delta 13
      vecs[1]  = '{14'h2AAA, 14'h1555, 10'd7,  14'd27,    1'b0, 3'd2, 2'd3, 1'b0, 5}; // 2a, delta 3
      vecs[2]  = '{14'h2AAA, 14'h1555, 10'd7,  14'd19,    1'b0, 3'd6, 2'd3, 1'b0, 4}; // 2b, delta 11
      vecs[3]  = '{14'h1555, 14'h1555, 10'd10, 14'd14,    1'b1, 3'd7, 2'd1, 1'b0, 2}; // reverse, B
      vecs[4]  = '{14'h1555, 14'h1555, 10'd20, 14'd40,    1'b0, 3'd7, 2'd2, 1'b0, 2}; // r=-10: delta 22
      vecs[5]  = '{14'h1555, 14'h1555, 10'd13, 14'd17,    1'b0, 3'd7, 2'd1, 1'b0, 2}; // delta == diff_sum
      vecs[6]  = '{14'h1555, 14'h0E55, 10'd13, 14'd18,    1'b0, 3'd5, 2'd0, 1'b0, 8}; // delta == diff_sum-1
      vecs[7]  = '{14'h1555, 14'h0E55, 10'd13, 14'd22,    1'b0, 3'd2, 2'd0, 1'b0, 5}; // mixed diff, 2a
      vecs[8]  = '{14'h1555, 14'h1555, 10'd7,  14'd30,    1'b0, 3'd0, 2'd0, 1'b0, 0}; // delta 0, gamma 4
      vecs[9]  = '{14'h0000, 14'h1555, 10'd7,  14'd13,    1'b0, 3'd4, 2'd1, 1'b0, 6}; // 2b, match at j=3
      vecs[10] = '{14'h2AAA, 14'h1555, 10'd7,  14'd15,    1'b0, 3'd0, 2'd3, 1'b1, 9}; // 2b no-match
      vecs[11] = '{14'h2AAA, 14'h1555, 10'd20, 14'd15,    1'b0, 3'd6, 2'd3, 1'b1, 9}; // 2a exhaustion
      vecs[12] = '{14'h2AAA, 14'h1555, 10'd7,  14'd16,    1'b1, 3'd6, 2'd3, 1'b0, 4}; // reverse 2b
      vecs[13] = '{14'h1555, 14'h1555, 10'd23, 14'd100,   1'b0, 3'd7, 2'd2, 1'b0, 2}; // r=-70: delta 26
      vecs[14] = '{14'h1555, 14'h1555, 10'd28, 14'd16383, 1'b0, 3'd7, 2'd3, 1'b0, 2}; // r=-16353: delta 31

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drive(vecs[0]);
      repeat (2) @(posedge clk);
      #1;
      check("reset in_ready", in_ready, 1);
      check("reset out_valid", out_valid, 0);
      check("reset index", miss_index, 0);
      check("reset digit", miss_digit, 0);
`ifdef DELLOC_NOMATCH_ERR_EN
      check("reset err", out_err, 0);
`endif
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Table of directed vectors, each consumed immediately.
      for (int i = 0; i < 15; i++) begin
         run_vec(i, vecs[i]);
         @(posedge clk); #1;
         check($sformatf("v%0d consumed", i), out_valid, 0);
      end

      // Backpressure: hold the result for 5 cycles while a new request waits.
      out_ready = 1'b0;
      run_vec(100, vecs[1]);
      drive(vecs[0]);
      in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         check($sformatf("bp%0d out_valid", c), out_valid, 1);
         check($sformatf("bp%0d in_ready", c), in_ready, 0);
         check($sformatf("bp%0d index", c), miss_index, 2);
         check($sformatf("bp%0d digit", c), miss_digit, 3);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp release out_valid", out_valid, 0);
      check("bp release in_ready", in_ready, 1);
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         check($sformatf("bp idle%0d out_valid", c), out_valid, 0);
         check($sformatf("bp idle%0d in_ready", c), in_ready, 1);
      end

      // Reset in the middle of a long SCAN_B search.
      drive(vecs[10]);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("mid busy in_ready", in_ready, 0);
      rst_n = 1'b0;
      #1;
      check("mid reset out_valid", out_valid, 0);
      check("mid reset in_ready", in_ready, 1);
      check("mid reset index", miss_index, 0);
      check("mid reset digit", miss_digit, 0);
`ifdef DELLOC_NOMATCH_ERR_EN
      check("mid reset err", out_err, 0);
`endif
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("after reset in_ready", in_ready, 1);
      run_vec(200, vecs[2]);
      @(posedge clk); #1;
      check("after reset consumed", out_valid, 0);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
